// File: rtl/data_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_packer_if
//  Description : Streaming handshake bundle for data_packer.
//                Element input:  addr_i / addr_valid_i / addr_ready_o
//                Word output:    lowdim_data_o / lowdim_data_valid_o /
//                                lowdim_data_ready_i
//                slave  modport : packer side
//                master modport : producer/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_packer_if #(
    parameter int LowDimWidth = 64,
    parameter int ImAddrWidth = 10
);
    logic [ImAddrWidth-1:0] addr_i;
    logic                   addr_valid_i;
    logic                   addr_ready_o;
    logic [LowDimWidth-1:0] lowdim_data_o;
    logic                   lowdim_data_valid_o;
    logic                   lowdim_data_ready_i;

    modport slave (
        input  addr_i,
        input  addr_valid_i,
        output addr_ready_o,
        output lowdim_data_o,
        output lowdim_data_valid_o,
        input  lowdim_data_ready_i
    );

    modport master (
        output addr_i,
        output addr_valid_i,
        input  addr_ready_o,
        input  lowdim_data_o,
        input  lowdim_data_valid_o,
        output lowdim_data_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/data_packer.sv
`default_nettype none
// ============================================================================
//  Module      : data_packer
//  Description : Packs item-memory element addresses into LowDimWidth-bit
//                words. Mode 0 forwards each element as a whole word; modes
//                1/2/3 pack 1/4/8-bit slices LSB-first, flushing a word when
//                it is full or when a vector of csr_elem_size_i elements ends.
//                Finished words go through a small non-fall-through FIFO.
//  Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//                enable_i          - block enable (low discards partial word)
//                clr_i             - soft clear (FIFO + partial word)
//                sel_mode_i        - 0=64b, 1=1b, 2=4b, 3=8b
//                csr_elem_size_i   - elements per vector (0 = no vector end)
//                bus (slave)       - element input / packed word output
//  Revision    : 1.0 - initial release
// ============================================================================
module data_packer #(
    parameter int LowDimWidth     = 64,
    parameter int NumTotIm        = 1024,
    parameter int PackerFifoDepth = 4,
    parameter int CsrDataWidth    = 32,
    localparam int ImAddrWidth    = $clog2(NumTotIm),
    localparam int ModeWidth      = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    clr_i,
    input  logic [ModeWidth-1:0]    sel_mode_i,
    input  logic [CsrDataWidth-1:0] csr_elem_size_i,
    data_packer_if.slave            bus
);
    localparam int c_PTR_W   = (PackerFifoDepth > 1) ? $clog2(PackerFifoDepth) : 1;
    localparam int c_CNT_W   = $clog2(PackerFifoDepth + 1);
    localparam int c_CHUNK_W = $clog2(LowDimWidth) + 1;
    localparam int c_OFF_W   = c_CHUNK_W + 3;

    localparam logic [ModeWidth-1:0] c_MODE_64B = 2'd0;
    localparam logic [ModeWidth-1:0] c_MODE_1B  = 2'd1;
    localparam logic [ModeWidth-1:0] c_MODE_4B  = 2'd2;
    localparam logic [ModeWidth-1:0] c_MODE_8B  = 2'd3;

    localparam logic [c_CHUNK_W-1:0]   c_LAST_1B = c_CHUNK_W'(LowDimWidth - 1);
    localparam logic [c_CHUNK_W-1:0]   c_LAST_4B = c_CHUNK_W'(LowDimWidth / 4 - 1);
    localparam logic [c_CHUNK_W-1:0]   c_LAST_8B = c_CHUNK_W'(LowDimWidth / 8 - 1);
    localparam logic [LowDimWidth-1:0] c_MASK_1B = LowDimWidth'(1);
    localparam logic [LowDimWidth-1:0] c_MASK_4B = LowDimWidth'(15);
    localparam logic [LowDimWidth-1:0] c_MASK_8B = LowDimWidth'(255);

    // Packing state
    logic [c_CHUNK_W-1:0]   r_chunk_cnt;
    logic [31:0]            r_elem_cnt;
    logic [LowDimWidth-1:0] r_accum;
    logic [ModeWidth-1:0]   r_prev_mode;

    // Output FIFO
    logic [LowDimWidth-1:0] r_mem [PackerFifoDepth];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_addr_ready;
    logic                   w_accept;
    logic                   w_restart;
    logic                   w_mode_64;
    logic [c_CHUNK_W-1:0]   w_chunk_cur;
    logic [31:0]            w_elem_cur;
    logic [LowDimWidth-1:0] w_accum_cur;
    logic [LowDimWidth-1:0] w_addr_ext;
    logic [LowDimWidth-1:0] w_slice;
    logic [c_OFF_W-1:0]     w_bit_off;
    logic                   w_last_chunk;
    logic [31:0]            w_size32;
    logic                   w_elem_finish;
    logic [LowDimWidth-1:0] w_packed;
    logic                   w_push;
    logic [LowDimWidth-1:0] w_push_data;
    logic                   w_pop;

    assign w_full       = (r_count == c_CNT_W'(PackerFifoDepth));
    assign w_empty      = (r_count == '0);
    // Ready deliberately ignores a same-cycle pop so the full flag is purely registered.
    assign w_addr_ready = enable_i && !w_full && !rst_i;
    // An element offered during a soft clear is dropped.
    assign w_accept     = bus.addr_valid_i && w_addr_ready && !clr_i;
    assign w_mode_64    = (sel_mode_i == c_MODE_64B);

    // A mode switch restarts packing in the same cycle, so an element accepted
    // right at the switch lands at offset 0 of the new mode.
    assign w_restart   = !enable_i || (sel_mode_i != r_prev_mode);
    assign w_chunk_cur = w_restart ? '0 : r_chunk_cnt;
    assign w_elem_cur  = w_restart ? '0 : r_elem_cnt;
    assign w_accum_cur = w_restart ? '0 : r_accum;

    assign w_addr_ext  = LowDimWidth'(bus.addr_i);

    always_comb begin
        w_slice      = w_addr_ext;
        w_bit_off    = '0;
        w_last_chunk = 1'b0;
        case (sel_mode_i)
            c_MODE_1B: begin
                w_slice      = w_addr_ext & c_MASK_1B;
                w_bit_off    = {3'b000, w_chunk_cur};
                w_last_chunk = (w_chunk_cur == c_LAST_1B);
            end
            c_MODE_4B: begin
                w_slice      = w_addr_ext & c_MASK_4B;
                w_bit_off    = {1'b0, w_chunk_cur, 2'b00};
                w_last_chunk = (w_chunk_cur == c_LAST_4B);
            end
            c_MODE_8B: begin
                w_slice      = w_addr_ext & c_MASK_8B;
                w_bit_off    = {w_chunk_cur, 3'b000};
                w_last_chunk = (w_chunk_cur == c_LAST_8B);
            end
            default: begin
                w_slice      = w_addr_ext;
                w_bit_off    = '0;
                w_last_chunk = 1'b0;
            end
        endcase
    end

    // A zero vector size never ends a vector; words then flush only when full.
    assign w_size32      = 32'(csr_elem_size_i);
    assign w_elem_finish = (w_size32 != 32'd0) && (w_elem_cur == w_size32 - 32'd1);

    assign w_packed    = w_accum_cur | (w_slice << w_bit_off);
    assign w_push      = w_accept && (w_mode_64 || w_last_chunk || w_elem_finish);
    assign w_push_data = w_mode_64 ? w_addr_ext : w_packed;
    assign w_pop       = bus.lowdim_data_ready_i && !w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chunk_cnt <= '0;
            r_elem_cnt  <= '0;
            r_accum     <= '0;
            r_prev_mode <= c_MODE_64B;
        end else if (clr_i) begin
            r_chunk_cnt <= '0;
            r_elem_cnt  <= '0;
            r_accum     <= '0;
            r_prev_mode <= sel_mode_i;
        end else begin
            r_prev_mode <= sel_mode_i;
            if (w_accept && !w_mode_64) begin
                if (w_last_chunk || w_elem_finish) begin
                    r_chunk_cnt <= '0;
                    r_accum     <= '0;
                end else begin
                    r_chunk_cnt <= w_chunk_cur + c_CHUNK_W'(1);
                    r_accum     <= w_packed;
                end
                // Only a vector end resets the element count; a full word does not.
                r_elem_cnt <= w_elem_finish ? 32'd0 : w_elem_cur + 32'd1;
            end else begin
                r_chunk_cnt <= w_chunk_cur;
                r_elem_cnt  <= w_elem_cur;
                r_accum     <= w_accum_cur;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(PackerFifoDepth - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(PackerFifoDepth - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the output is gated to zero while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign bus.addr_ready_o        = w_addr_ready;
    assign bus.lowdim_data_valid_o = !w_empty;
    assign bus.lowdim_data_o       = w_empty ? '0 : r_mem[r_rd_ptr];
endmodule
`default_nettype wire

// File: doc/data_packer.md
DATA_PACKER -- requirements
Module: data_packer

Interface
REQ-001 SHALL have parameter LowDimWidth, default 64, output word width in bits.
REQ-002 SHALL have parameter NumTotIm, default 1024, item-memory depth; ImAddrWidth = clog2(NumTotIm), derived, not overridden.
REQ-003 SHALL have parameter PackerFifoDepth, default 4, output FIFO depth in words.
REQ-004 SHALL have parameter CsrDataWidth, default 32, CSR width; ModeWidth = 2, fixed.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk_i  input  1  clock; rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have ports: enable_i  input  1  block enable; clr_i  input  1  synchronous soft clear; sel_mode_i  input  2  0=64b, 1=1b, 2=4b, 3=8b.
REQ-007 SHALL have ports: csr_elem_size_i  input  CsrDataWidth  elements per vector.
REQ-008 SHALL have ports: addr_i  input  ImAddrWidth  element in; addr_valid_i  input  1; addr_ready_o  output  1.
REQ-009 SHALL have ports: lowdim_data_o  output  LowDimWidth  packed word; lowdim_data_valid_o  output  1; lowdim_data_ready_i  input  1.

Function
REQ-010 SHALL accept an element when addr_valid_i && addr_ready_o; addr_ready_o = enable_i && !fifo_full, 0 while rst_i is high.
REQ-011 Mode 64b SHALL push addr_i zero-extended to LowDimWidth as one word per accepted element; no chunk or element counting.
REQ-012 Modes 1b/4b/8b SHALL write addr_i[0], [3:0] or [7:0] into an accumulator at bit offset chunk_count*W (W=1/4/8); unwritten bits stay 0.
REQ-013 Chunk counter SHALL increment per accepted element; max chunks = LowDimWidth/W (64/16/8).
REQ-014 Element counter (32b) SHALL increment per accepted element; element-finish = accepted element with elem_count == csr_elem_size_i-1.
REQ-015 csr_elem_size_i == 0 SHALL disable element-finish; words flush only on full chunk.
REQ-016 On accepting the last chunk (chunk_count == max-1) or an element-finish, the word SHALL be the accumulator OR'd with the new slice, pushed to the FIFO that cycle, and chunk counter and accumulator SHALL clear.
REQ-017 Element-finish SHALL also clear the element counter; chunk-full alone SHALL NOT.
REQ-018 Latency: lowdim_data_valid_o SHALL rise one cycle after the completing element is accepted (non-fall-through FIFO).
REQ-019 lowdim_data_valid_o = FIFO not empty; pop on lowdim_data_ready_i && valid, independent of enable_i, so the FIFO drains while disabled.
REQ-020 Words SHALL leave in push order; push and pop in the same cycle SHALL both take effect.
REQ-021 When FIFO is full addr_ready_o SHALL be 0, even if a pop occurs that cycle.
REQ-022 enable_i low or a sel_mode_i change SHALL clear counters and accumulator next cycle, discarding any partial word; FIFO contents are kept.
REQ-023 clr_i SHALL empty the FIFO and clear counters and accumulator next cycle; an element presented that cycle SHALL be dropped.

Reset
REQ-024 rst_i high SHALL zero counters, accumulator and FIFO pointers; lowdim_data_valid_o = 0 and lowdim_data_o = 0 after reset.
REQ-025 rst_i mid-word SHALL discard the partial word; the first element after reset starts at offset 0.

Verification
REQ-026 Mode 8b, elem_size 8, elements 0x01..0x08 -> one word 0x0807060504030201, valid one cycle after the 8th accept.
REQ-027 Mode 1b, elem_size 3, bits 1,0,1 -> word 0x5; next element lands at bit 0.
REQ-028 Mode 4b, elem_size 20, 16 x 0xF then 0x1..0x4 -> words 0xFFFFFFFFFFFFFFFF then 0x4321.
REQ-029 Mode 64b, addr 0x3FF -> word 0x00000000000003FF per element.
REQ-030 Mode 8b, lowdim_data_ready_i=0, 32 elements -> addr_ready_o low after 4 words; on release, 4 words emerge in order and input resumes.
REQ-031 Mode 8b, 3 elements, then clr_i -> FIFO empty, valid low; next 8 elements form a word from byte 0.
